serial_rx4: RTL and testbench
=============================

// Module: serial_rx4
// PURPOSE
//   Downstream consumer of the 4-bit shift stage's serial output. Frames the
//   one-bit-per-clock stream (start bit, DATA_W data bits LSB first, optional
//   parity, stop bit) and rebuilds a parallel word.
//   The word is held with valid/ack handshake and framing, parity and overrun status.
// PARAMETERS
//   DATA_W  4  data bits per frame; legal range 2..8
// PORTS
//   clk         in   1       single clock; all state changes on posedge
//   rst         in   1       asynchronous, active-high reset
//   s_in        in   1       serial line; idles 0; one bit per clk
//   ack         in   1       consumer accepts p_out; clears valid and overrun
//   p_out       out  DATA_W  last accepted word; bit 0 = first data bit received
//   valid       out  1       p_out holds an unacknowledged word
//   frame_err   out  1       1-cycle pulse: stop bit sampled as 1
//   parity_err  out  1       1-cycle pulse: parity mismatch (0 without PARITY_EN)
//   overrun     out  1       sticky: good frame dropped because valid=1 and ack=0
//   busy        out  1       FSM not in IDLE
// BEHAVIOUR
//   Reset: asynchronous, active-high. FSM goes to IDLE. p_out, valid,
//     frame_err, parity_err, overrun and busy all reset to 0.
//   Reset mid-frame: the partial frame is discarded. The first clock edge
//     after rst deasserts samples s_in in IDLE.
//   FSM states: IDLE, DATA, PAR, STOP.
//     IDLE: s_in=1 samples a start bit and goes to DATA; bit counter = 0.
//     DATA: shift s_in into bit cnt of the assembly register.
//       Counter wraps after DATA_W-1. Then go to PAR (PARITY_EN) or STOP.
//     PAR: sample the parity bit, then go to STOP.
//     STOP: sample the stop bit, then go to IDLE.
//   A frame starting the cycle after a stop bit is received without gap.
//   Frame length: 2+DATA_W bits, or 3+DATA_W bits with PARITY_EN.
//   Stop-sample edge decisions:
//     stop=1: frame_err pulses; word discarded.
//     parity bad: parity_err pulses; word discarded.
//     Both bad: both pulses assert; word discarded.
//     Good frame: word offered to the holding register.
//   Holding register, evaluated on the stop-sample edge:
//     valid=0 -> load p_out; valid<=1.
//     valid=1, ack=1 -> load new word; valid stays 1; no overrun.
//     valid=1, ack=0 -> word dropped; p_out kept; overrun<=1.
//   ack with no capture: valid<=0 and overrun<=0 next edge.
//     ack while valid=0 is a no-op.
//   Latency: valid is visible the cycle after the stop bit is presented.
//   busy = (state != IDLE), registered with the state.
// CONFIGURATION
//   PARITY_RX_EN defined:
//     PAR state is present; even parity is checked.
//     XOR of the data bits and the parity bit must equal 0.
//   PARITY_RX_EN undefined:
//     No PAR state; parity_err is tied to 0.
//     Frame is start, data and stop bits only.
// STRUCTURE
//   Package serial_pkg:
//     rx_state_t enum {IDLE, DATA, PAR, STOP}
//     DATA_W_DEF = 4
//     START_BIT = 1'b1, STOP_BIT = 1'b0, IDLE_LVL = 1'b0
//   Top level: FSM, bit counter, assembly shift register.
//   One sub-module, rx_hold_reg: p_out, valid and overrun with
//     load/ack arbitration as specified above.
// TESTING
//   1 rst high mid-frame, release, idle line -> all outputs 0, busy=0.
//   2 s_in 1,1,1,0,1,0 (no parity) -> p_out=4'hB, valid=1 one cycle after stop;
//     ack -> valid=0.
//   3 Same frame with stop=1 -> frame_err single pulse, valid stays 0,
//     FSM back to IDLE.
//   4 Two back-to-back good frames 4'hB then 4'h6, no ack ->
//     p_out=4'hB, overrun=1; ack -> both cleared.
//   5 ack asserted on the second frame's stop-sample edge ->
//     p_out=4'h6, valid=1, overrun=0.
//   6 PARITY_RX_EN: frame 4'hB with parity 1 -> accepted;
//     parity 0 -> parity_err pulse, no valid.

Source files
------------

// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
//   Shared definitions for the serial receive path: FSM state encoding,
//   default data width and the line levels that frame a serial word.
//   No ports (package).
// -----------------------------------------------------------------------------
package serial_pkg;

    // Receiver FSM states as plain constants so older tools and testbenches can
    // compare against them directly.
    typedef logic [1:0] rx_state_t;

    localparam rx_state_t IDLE = 2'd0;
    localparam rx_state_t DATA = 2'd1;
    localparam rx_state_t PAR  = 2'd2;
    localparam rx_state_t STOP = 2'd3;

    localparam int unsigned DATA_W_DEF = 4;

    // Line levels. The line idles low, so a start bit is a high sample and a
    // good stop bit returns the line to the idle level.
    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;
    localparam logic IDLE_LVL  = 1'b0;

    // A frame is kept only when the stop bit is correct and parity is clean.
    function automatic logic frame_good(input logic stop_bit, input logic par_bad);
        return (stop_bit == STOP_BIT) && !par_bad;
    endfunction

endpackage

// File: rtl/rx_hold_reg.sv
// -----------------------------------------------------------------------------
// rx_hold_reg
//   Output holding register for the serial receiver. Holds the last accepted
//   word with a valid/ack handshake and a sticky overrun flag.
//
//   Ports
//     clk        in   clock, state changes on posedge
//     rst        in   asynchronous active-high reset
//     load_i     in   a good frame is offered this cycle
//     word_i     in   the offered word
//     ack_i      in   consumer accepts p_out_o
//     p_out_o    out  held word
//     valid_o    out  p_out_o holds an unacknowledged word
//     overrun_o  out  sticky: a good frame was dropped while valid_o=1, ack_i=0
// -----------------------------------------------------------------------------
module rx_hold_reg #(
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic              ack_i,
    output logic [DATA_W-1:0] p_out_o,
    output logic              valid_o,
    output logic              overrun_o
);

    logic [DATA_W-1:0] p_out_d, p_out_q;
    logic              valid_d, valid_q;
    logic              overrun_d, overrun_q;

    always_comb begin
        p_out_d   = p_out_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (load_i) begin
            if (!valid_q || ack_i) begin
                // Slot is free, or is being freed this edge: take the new word.
                // A concurrent ack also retires any pending overrun.
                p_out_d   = word_i;
                valid_d   = 1'b1;
                overrun_d = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (ack_i) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_out_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            p_out_q   <= p_out_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign p_out_o   = p_out_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/serial_rx4.sv
// -----------------------------------------------------------------------------
// serial_rx4
//   Serial-to-parallel receiver for the 4-bit shift stage's output. Frames a
//   one-bit-per-clock stream (start, DATA_W data bits LSB first, optional even
//   parity, stop) and hands good words to a valid/ack holding register.
//
//   Build option: define PARITY_RX_EN to add the parity bit and even-parity
//   check; otherwise parity_err is constant 0.
//
//   Ports
//     clk         in   clock, state changes on posedge
//     rst         in   asynchronous active-high reset
//     s_in        in   serial line, idles 0
//     ack         in   consumer accepts p_out; clears valid and overrun
//     p_out       out  last accepted word, bit 0 = first data bit
//     valid       out  p_out holds an unacknowledged word
//     frame_err   out  1-cycle pulse: stop bit sampled as 1
//     parity_err  out  1-cycle pulse: parity mismatch
//     overrun     out  sticky: good frame dropped while valid=1 and ack=0
//     busy        out  FSM not in IDLE
// -----------------------------------------------------------------------------
module serial_rx4
    import serial_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_in,
    input  logic              ack,
    output logic [DATA_W-1:0] p_out,
    output logic              valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun,
    output logic              busy
);

    // Three bits cover the full 2..8 data-width range.
    localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

    rx_state_t         state_d, state_q;
    logic [2:0]        cnt_d, cnt_q;
    logic [DATA_W-1:0] shreg_d, shreg_q;
    logic              frame_err_d, frame_err_q;
    logic              parity_err_d, parity_err_q;
    logic              busy_d, busy_q;
    logic              load;
    logic              par_bad;

`ifdef PARITY_RX_EN
    localparam rx_state_t AFTER_DATA = PAR;
    logic par_d, par_q;

    // Even parity: data bits together with the parity bit must XOR to 0.
    assign par_bad = ^{shreg_q, par_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`else
    localparam rx_state_t AFTER_DATA = STOP;
    assign par_bad = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        load         = 1'b0;
`ifdef PARITY_RX_EN
        par_d        = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (s_in == START_BIT) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                // Shift in from the top: after DATA_W bits the first one
                // received sits in bit 0.
                shreg_d = {s_in, shreg_q[DATA_W-1:1]};
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = AFTER_DATA;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
`ifdef PARITY_RX_EN
            PAR: begin
                par_d   = s_in;
                state_d = STOP;
            end
`endif
            STOP: begin
                frame_err_d  = (s_in != STOP_BIT);
                parity_err_d = par_bad;
                load         = frame_good(s_in, par_bad);
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            busy_q       <= busy_d;
        end
    end

    // shreg_d carries the final data bit only when leaving DATA, but at the
    // stop edge shreg_q already holds the complete word.
    rx_hold_reg #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .word_i    (shreg_q),
        .ack_i     (ack),
        .p_out_o   (p_out),
        .valid_o   (valid),
        .overrun_o (overrun)
    );

    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_serial_rx4.sv
// -----------------------------------------------------------------------------
// tb_serial_rx4
//   Scoreboard bench for serial_rx4 (DATA_W = 4). Stimulus queues the expected
//   output snapshot {p_out, valid, overrun, frame_err, parity_err} for every
//   change it causes; a monitor pops one entry per observed change.
//   Define PARITY_RX_EN to run the parity frames as well.
// -----------------------------------------------------------------------------
module tb_serial_rx4;
    import serial_pkg::*;

    localparam int unsigned DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_in = 1'b0;
    logic          ack = 1'b0;
    logic [DW-1:0] p_out;
    logic          valid;
    logic          frame_err;
    logic          parity_err;
    logic          overrun;
    logic          busy;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    bit          mon_en  = 1'b0;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    serial_rx4 #(
        .DATA_W (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_in       (s_in),
        .ack        (ack),
        .p_out      (p_out),
        .valid      (valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    function automatic logic [7:0] snap();
        return {p_out, valid, overrun, frame_err, parity_err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic push(input logic [3:0] p, input logic v, input logic o,
                        input logic fe, input logic pe);
        exp_q.push_back({p, v, o, fe, pe});
    endtask

    task automatic send_bit(input logic b);
        s_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
    endtask

    // Full frame; ack_stop raises ack only for the stop-sample edge.
    task automatic send_frame(input logic [3:0] d, input logic par, input logic stop,
                              input logic ack_stop);
        send_bit(START_BIT);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
`ifdef PARITY_RX_EN
        send_bit(par);
`else
        if (par) begin end
`endif
        ack = ack_stop;
        send_bit(stop);
        ack = 1'b0;
        s_in = IDLE_LVL;
    endtask

    // Monitor: every change of the observed outputs must match the next entry.
    initial begin : monitor
        logic [7:0] prev;
        logic [7:0] cur;
        logic [7:0] e;
        wait (mon_en);
        prev = snap();
        forever begin
            @(negedge clk);
            cur = snap();
            if (cur !== prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {24'd0, cur}, {24'd0, prev});
                end else begin
                    e = exp_q.pop_front();
                    check("event", {24'd0, cur}, {24'd0, e});
                end
                prev = cur;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // 1: reset during a partial frame, then idle.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);
        check("busy_mid_frame", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("busy_async_rst", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) send_bit(IDLE_LVL);
        check("reset_outputs", {24'd0, snap()}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        mon_en = 1'b1;
        @(negedge clk);

        // 2: good frame 4'hB, then ack.
        push(4'hB, 1, 0, 0, 0);
        send_frame(4'hB, 1'b1, STOP_BIT, 1'b0);
        check("valid_latency", {31'd0, valid}, 32'd1);
        check("p_out_b", {28'd0, p_out}, 32'hB);
        check("busy_after_stop", {31'd0, busy}, 32'd0);
        push(4'hB, 0, 0, 0, 0);
        ack_pulse();
        check("valid_cleared", {31'd0, valid}, 32'd0);

        // 3: bad stop bit.
        push(4'hB, 0, 0, 1, 0);
        push(4'hB, 0, 0, 0, 0);
        send_frame(4'hB, 1'b1, ~STOP_BIT, 1'b0);
        check("frame_err_pulse", {31'd0, frame_err}, 32'd1);
        check("frame_err_busy", {31'd0, busy}, 32'd0);
        send_bit(IDLE_LVL);
        check("frame_err_once", {31'd0, frame_err}, 32'd0);
        check("frame_err_no_valid", {31'd0, valid}, 32'd0);

        // 4: back-to-back frames without ack -> overrun.
        push(4'hB, 1, 0, 0, 0);
        push(4'hB, 1, 1, 0, 0);
        send_frame(4'hB, 1'b1, STOP_BIT, 1'b0);
        send_frame(4'h6, 1'b0, STOP_BIT, 1'b0);
        check("overrun_p_out", {28'd0, p_out}, 32'hB);
        send_bit(IDLE_LVL);
        push(4'hB, 0, 0, 0, 0);
        ack_pulse();
        check("overrun_cleared", {31'd0, overrun}, 32'd0);

        // 5: ack on the second frame's stop edge replaces the word.
        push(4'hB, 1, 0, 0, 0);
        push(4'h6, 1, 0, 0, 0);
        send_frame(4'hB, 1'b1, STOP_BIT, 1'b0);
        send_frame(4'h6, 1'b0, STOP_BIT, 1'b1);
        check("ack_on_stop_p_out", {28'd0, p_out}, 32'h6);
        check("ack_on_stop_overrun", {31'd0, overrun}, 32'd0);
        push(4'h6, 0, 0, 0, 0);
        ack_pulse();

`ifdef PARITY_RX_EN
        // 6: even parity.
        push(4'hB, 1, 0, 0, 0);
        send_frame(4'hB, 1'b1, STOP_BIT, 1'b0);
        check("parity_good_valid", {31'd0, valid}, 32'd1);
        push(4'hB, 0, 0, 0, 0);
        ack_pulse();
        push(4'hB, 0, 0, 0, 1);
        push(4'hB, 0, 0, 0, 0);
        send_frame(4'hB, 1'b0, STOP_BIT, 1'b0);
        check("parity_err_pulse", {31'd0, parity_err}, 32'd1);
        send_bit(IDLE_LVL);
        check("parity_err_once", {31'd0, parity_err}, 32'd0);
        push(4'hB, 0, 0, 1, 1);
        push(4'hB, 0, 0, 0, 0);
        send_frame(4'hB, 1'b0, ~STOP_BIT, 1'b0);
        check("both_err_no_valid", {31'd0, valid}, 32'd0);
`endif

        // Drain: every queued event must have been seen.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
